// File: rtl/uart_tx_param.sv
// FIFO-buffered UART transmitter: start bit, DATA_BITS data bits LSB first, STOP_BITS stop cells.
// Define UART_TX_PARITY_EN to add a parity cell after the data bits and the parity_odd input.
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          uart_samplig_clk,
  input  logic                          reset,
  input  logic                          valid,
  output logic                          ready,
  input  logic [DATA_BITS-1:0]          data_to_xmit,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic                          RsTx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS);

  localparam logic [CW-1:0]   FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0] STOP_LAST = BC_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  // Transmit FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_d;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;

  assign ready      = (count_q != FULL_CNT);
  assign push       = valid && ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  always_ff @(posedge uart_samplig_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_to_xmit;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge uart_samplig_clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Frame sequencer
  logic [2:0]           state_q;
  logic [2:0]           state_d;
  logic [PH_W-1:0]      phase_q;
  logic [PH_W-1:0]      phase_d;
  logic [BC_W-1:0]      bit_q;
  logic [BC_W-1:0]      bit_d;
  logic                 rstx_q;
  logic                 rstx_d;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] shreg_d;
  logic                 cell_end;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
  logic                 par_d;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction
`endif

  assign cell_end = (phase_q == PH_LAST);
  assign busy     = (state_q != S_IDLE);
  assign RsTx     = rstx_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    rstx_d  = rstx_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != S_IDLE) begin
      phase_d = cell_end ? '0 : phase_q + PH_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      S_START: begin
        if (cell_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          rstx_d  = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      S_DATA: begin
        if (cell_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            rstx_d  = par_q;
`else
            state_d = S_STOP;
            rstx_d  = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + BC_W'(1);
            rstx_d  = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cell_end) begin
          state_d = S_STOP;
          rstx_d  = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cell_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // A queued word starts its frame on this edge, with no idle cycle in between
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
              rstx_d  = 1'b1;
            end
          end else begin
            bit_d  = bit_q + BC_W'(1);
            rstx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        rstx_d  = 1'b1;
      end
    endcase

    // The popped word is latched whole so later FIFO writes cannot disturb the frame
    if (pop) begin
      state_d = S_START;
      phase_d = '0;
      bit_d   = '0;
      rstx_d  = 1'b0;
      shreg_d = head;
`ifdef UART_TX_PARITY_EN
      par_d   = parity_bit(head, parity_odd);
`endif
    end
  end

  always_ff @(posedge uart_samplig_clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      rstx_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      rstx_q  <= rstx_d;
    end
  end

  always_ff @(posedge uart_samplig_clk) begin
    shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: default instance plus a 7-bit / 2-stop / OVERSAMPLE=4 / depth-2 instance.
// A serial-line monitor per instance decodes each frame against a queue of expected words.
`timescale 1ns/1ps
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
  localparam int PAR_CELLS = 1;
`else
  localparam int PAR_CELLS = 0;
`endif
  localparam int OS_A = 16;
  localparam int DB_A = 8;
  localparam int SB_A = 1;
  localparam int OS_B = 4;
  localparam int DB_B = 7;
  localparam int SB_B = 2;
  localparam int FRAME_A = (1 + DB_A + PAR_CELLS + SB_A) * OS_A;
  localparam int FRAME_B = (1 + DB_B + PAR_CELLS + SB_B) * OS_B;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_a, ready_a, rstx_a, busy_a, par_a;
  logic [7:0] data_a;
  logic [2:0] cnt_a;
  logic       valid_b, ready_b, rstx_b, busy_b, par_b;
  logic [6:0] data_b;
  logic [1:0] cnt_b;

  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];
  int         starts_a[$];
  int         starts_b[$];
  int         frames_a = 0;
  int         frames_b = 0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_param u_a (
    .uart_samplig_clk (clk),
    .reset            (rst_n),
    .valid            (valid_a),
    .ready            (ready_a),
    .data_to_xmit     (data_a),
`ifdef UART_TX_PARITY_EN
    .parity_odd       (par_a),
`endif
    .RsTx             (rstx_a),
    .busy             (busy_a),
    .fifo_count       (cnt_a)
  );

  uart_tx_param #(
    .DATA_BITS  (7),
    .OVERSAMPLE (4),
    .STOP_BITS  (2),
    .FIFO_DEPTH (2)
  ) u_b (
    .uart_samplig_clk (clk),
    .reset            (rst_n),
    .valid            (valid_b),
    .ready            (ready_b),
    .data_to_xmit     (data_b),
`ifdef UART_TX_PARITY_EN
    .parity_odd       (par_b),
`endif
    .RsTx             (rstx_b),
    .busy             (busy_b),
    .fifo_count       (cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected entry: [8] = parity cell value, [7:0] = data masked to nd bits
  function automatic logic [8:0] mk(input logic [7:0] w, input int nd, input logic p);
    logic [7:0] m;
    m = w & 8'((9'd1 << nd) - 9'd1);
    return {(^m) ^ p, m};
  endfunction

  function automatic logic cell_bit(input logic [8:0] e, input int c, input int nd);
    if (c == 0) return 1'b0;
    if (c <= nd) return e[c-1];
    if (PAR_CELLS == 1 && c == nd + 1) return e[8];
    return 1'b1;
  endfunction

  function automatic logic line_of(input int idx);
    return (idx == 0) ? rstx_a : rstx_b;
  endfunction

  function automatic logic busy_of(input int idx);
    return (idx == 0) ? busy_a : busy_b;
  endfunction

  function automatic int cnt_of(input int idx);
    return (idx == 0) ? int'(cnt_a) : int'(cnt_b);
  endfunction

  function automatic int qsize(input int idx);
    return (idx == 0) ? exp_a.size() : exp_b.size();
  endfunction

  function automatic logic [8:0] qpop(input int idx);
    if (idx == 0) return exp_a.pop_front();
    return exp_b.pop_front();
  endfunction

  task automatic monitor(input int idx);
    int         os, nd, ns, ncells, mism;
    logic [8:0] e;
    logic       eb, abort, have;
    os = (idx == 0) ? OS_A : OS_B;
    nd = (idx == 0) ? DB_A : DB_B;
    ns = (idx == 0) ? SB_A : SB_B;
    ncells = 1 + nd + PAR_CELLS + ns;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && line_of(idx) === 1'b0) begin
        have = (qsize(idx) != 0);
        check($sformatf("frame_expected_inst%0d", idx), {31'd0, have}, 32'd1);
        e = have ? qpop(idx) : 9'd0;
        if (idx == 0) begin
          starts_a.push_back(cyc);
          frames_a++;
        end else begin
          starts_b.push_back(cyc);
          frames_b++;
        end
        abort = 1'b0;
        for (int c = 0; c < ncells && !abort; c++) begin
          eb = cell_bit(e, c, nd);
          mism = 0;
          for (int ph = 0; ph < os; ph++) begin
            if (c != 0 || ph != 0) @(negedge clk);
            if (rst_n !== 1'b1) begin
              abort = 1'b1;
              break;
            end
            if (line_of(idx) !== eb || busy_of(idx) !== 1'b1) mism++;
          end
          if (!abort && have)
            check($sformatf("inst%0d_word%0h_cell%0d_bad_samples", idx, e[7:0], c), mism, 0);
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic wait_idle(input int idx, input int budget, input string tag);
    int   n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = (qsize(idx) == 0) && (busy_of(idx) === 1'b0) && (cnt_of(idx) == 0);
    end
    check({tag, "_drained"}, {31'd0, done}, 32'd1);
  endtask

  task automatic push_a(input logic [7:0] w);
    int g;
    g = 0;
    valid_a = 1'b1;
    data_a  = w;
    while (ready_a !== 1'b1 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) check("push_a_ready", {31'd0, ready_a}, 32'd1);
    @(posedge clk);
    exp_a.push_back(mk(w, DB_A, par_a));
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [6:0] w);
    int g;
    g = 0;
    valid_b = 1'b1;
    data_b  = w;
    while (ready_b !== 1'b1 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) check("push_b_ready", {31'd0, ready_b}, 32'd1);
    @(posedge clk);
    exp_b.push_back(mk({1'b0, w}, DB_B, par_b));
    @(negedge clk);
    valid_b = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    valid_a = 1'b0; data_a = '0; par_a = 1'b0;
    valid_b = 1'b0; data_b = '0; par_b = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rstx_a", rstx_a, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_cnt_a",  cnt_a, 0);
    check("rst_rstx_b", rstx_b, 1);
    check("rst_busy_b", busy_b, 0);
    check("rst_cnt_b",  cnt_b, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst_a", ready_a, 1);
    check("ready_after_rst_b", ready_b, 1);

    // Single 0x55 frame on the default instance, with exact start/end edges
    push_a(8'h55);
    check("t1_cnt_after_push", cnt_a, 1);
    check("t1_line_before_start", rstx_a, 1);
    @(negedge clk);
    check("t1_start_rstx", rstx_a, 0);
    check("t1_start_busy", busy_a, 1);
    check("t1_cnt_after_pop", cnt_a, 0);
    repeat (FRAME_A - 1) @(negedge clk);
    check("t1_last_cycle_busy", busy_a, 1);
    check("t1_last_cycle_rstx", rstx_a, 1);
    @(negedge clk);
    check("t1_end_busy", busy_a, 0);
    check("t1_end_rstx", rstx_a, 1);
    wait_idle(0, 100, "t1");

    // Single 0x41 frame on the 7-bit / 2-stop / OVERSAMPLE=4 instance
    push_b(7'h41);
    @(negedge clk);
    check("t2_start_rstx", rstx_b, 0);
    check("t2_start_busy", busy_b, 1);
    repeat (FRAME_B - 1) @(negedge clk);
    check("t2_last_cycle_busy", busy_b, 1);
    @(negedge clk);
    check("t2_end_busy", busy_b, 0);
    check("t2_end_rstx", rstx_b, 1);
    wait_idle(1, 100, "t2");

    // Back-to-back words on depth-4 FIFO: peak 3 with ready high, then fill to full
    starts_a.delete();
    push_a(8'h01);
    push_a(8'h02);
    push_a(8'h03);
    push_a(8'h04);
    check("t3_cnt_peak", cnt_a, 3);
    check("t3_ready_high", ready_a, 1);
    push_a(8'hA5);
    check("t3_cnt_full", cnt_a, 4);
    check("t3_ready_low_full", ready_a, 0);
    push_a(8'h5A);
    wait_idle(0, 8 * FRAME_A, "t3");
    check("t3_frames", starts_a.size(), 6);
    for (int i = 1; i < starts_a.size(); i++)
      check($sformatf("t3_gap_%0d", i), starts_a[i] - starts_a[i-1], FRAME_A);

    // Depth-2 FIFO with six words
    starts_b.delete();
    push_b(7'h11);
    push_b(7'h2A);
    push_b(7'h35);
    check("t4_cnt_full", cnt_b, 2);
    check("t4_ready_low", ready_b, 0);
    n = 0;
    while (ready_b !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t4_ready_rise", ready_b, 1);
    check("t4_cnt_at_rise", cnt_b, 1);
    push_b(7'h4C);
    push_b(7'h7F);
    push_b(7'h00);
    wait_idle(1, 8 * FRAME_B, "t4");
    check("t4_frames", starts_b.size(), 6);
    for (int i = 1; i < starts_b.size(); i++)
      check($sformatf("t4_gap_%0d", i), starts_b[i] - starts_b[i-1], FRAME_B);

`ifdef UART_TX_PARITY_EN
    // Parity cell for 0x07: even -> 1, odd -> 0
    par_a = 1'b0;
    push_a(8'h07);
    repeat (1 + 9 * OS_A + OS_A / 2) @(negedge clk);
    check("t5_parity_even_cell", rstx_a, 1);
    wait_idle(0, 2 * FRAME_A, "t5a");
    par_a = 1'b1;
    push_a(8'h07);
    @(negedge clk);
    n = 0;
    while (busy_a === 1'b1 && n < 1000) begin
      n++;
      if (n == 1 + 9 * OS_A + OS_A / 2) check("t5_parity_odd_cell", rstx_a, 0);
      @(negedge clk);
    end
    check("t5_frame_len", n, FRAME_A);
    wait_idle(0, 2 * FRAME_A, "t5b");
    par_a = 1'b0;
`endif

    // Reset during data bit 3 with two words queued
    push_a(8'h11);
    push_a(8'h22);
    push_a(8'h33);
    repeat (70) @(negedge clk);
    check("t6_busy_before_rst", busy_a, 1);
    check("t6_cnt_before_rst", cnt_a, 2);
    check("t6_bit3_value", rstx_a, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rstx_after_rst", rstx_a, 1);
    check("t6_busy_after_rst", busy_a, 0);
    check("t6_cnt_after_rst", cnt_a, 0);
    rst_n = 1'b1;
    exp_a.delete();
    n = frames_a;
    repeat (3 * FRAME_A) @(negedge clk);
    check("t6_no_more_frames", frames_a, n);
    check("t6_line_idle", rstx_a, 1);
    check("t6_busy_idle", busy_a, 0);
    check("t6_ready", ready_a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
